// File: rtl/spi_ip_pkg.sv
// Shared constants for the SPI master controller: FSM state encoding and
// bit positions inside the load_type control field.
package spi_ip_pkg;

    localparam int unsigned ST_WIDTH = 3;

    localparam logic [ST_WIDTH-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_WIDTH-1:0] ST_LOAD  = 3'd1;
    localparam logic [ST_WIDTH-1:0] ST_LEAD  = 3'd2;
    localparam logic [ST_WIDTH-1:0] ST_XFER  = 3'd3;
    localparam logic [ST_WIDTH-1:0] ST_TRAIL = 3'd4;
    localparam logic [ST_WIDTH-1:0] ST_DONE  = 3'd5;

    localparam int unsigned LT_WIDTH    = 2;
    localparam int unsigned LT_WORD_BIT = 0;  // 1 = full word, 0 = half word
    localparam int unsigned LT_LSB_BIT  = 1;  // 1 = LSB first, 0 = MSB first

endpackage

// File: rtl/spi_ip_clk_div.sv
// SCLK half-period divider: counts 0..terminal and flags the terminal cycle.
// pre_tick_c announces a tick one cycle early so strobes can be registered.
module spi_ip_clk_div #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] terminal,
    output logic                 tick,
    output logic                 pre_tick_c
);

    logic [DIV_WIDTH-1:0] count;
    logic                 tick_q;

    // terminal is never zero, so a tick is never followed directly by another
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            tick_q <= 1'b0;
        end else if (clear || !enable || tick_q) begin
            count  <= '0;
            tick_q <= 1'b0;
        end else begin
            count  <= count + DIV_WIDTH'(1);
            tick_q <= (count + DIV_WIDTH'(1)) == terminal;
        end
    end

    assign tick       = tick_q;
    assign pre_tick_c = enable && !clear && !tick_q && (count == terminal - DIV_WIDTH'(1));

endmodule

// File: rtl/spi_ip_master_ctrl.sv
// SPI master sequencing controller: frames a transfer with slave select, generates
// SCLK from a programmable divider and times the shift-register launch/capture strobes.
module spi_ip_master_ctrl
    import spi_ip_pkg::*;
#(
    parameter int unsigned PARAM_SR_WIDTH  = 16,
    parameter int unsigned PARAM_DIV_WIDTH = 8
) (
    input  logic                       mc_clk_i,
    input  logic                       mc_rst_n_i,
    input  logic                       mc_start_i,
    input  logic                       mc_abort_i,
    input  logic                       mc_cpol_i,
    input  logic                       mc_cpha_i,
    input  logic [LT_WIDTH-1:0]        mc_load_type_i,
    input  logic [PARAM_DIV_WIDTH-1:0] mc_clk_div_i,
    output logic                       mc_sclk_o,
    output logic                       mc_ss_n_o,
    output logic                       mc_sr_load_o,
    output logic                       mc_sr_enable_launch_o,
    output logic                       mc_sr_enable_capture_o,
    output logic                       mc_sr_enable_launch_capture_o,
    output logic [LT_WIDTH-1:0]        mc_sr_load_type_o,
    output logic                       mc_busy_o,
    output logic                       mc_done_o
);

    localparam int unsigned EDGE_W = $clog2(PARAM_SR_WIDTH) + 2;
    localparam logic [EDGE_W-1:0] LAST_WORD = EDGE_W'(2 * PARAM_SR_WIDTH - 1);
    localparam logic [EDGE_W-1:0] LAST_HALF = EDGE_W'(PARAM_SR_WIDTH - 1);

    logic [ST_WIDTH-1:0]        state;
    logic [ST_WIDTH-1:0]        state_next;
    logic                       cpol_q;
    logic                       cpha_q;
    logic [LT_WIDTH-1:0]        load_type_q;
    logic [PARAM_DIV_WIDTH-1:0] clk_div_q;
    logic [PARAM_DIV_WIDTH-1:0] div_term_c;
    logic [EDGE_W-1:0]          edge_cnt;
    logic [EDGE_W-1:0]          last_edge_c;
    logic                       last_q;
    logic                       sclk_q;
    logic                       ss_n_q;
    logic                       load_q;
    logic                       launch_q;
    logic                       capture_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       abort_c;
    logic                       div_en_c;
    logic                       div_clr_c;
    logic                       in_frame_c;
    logic                       launch_c;
    logic                       capture_c;
    logic                       last_c;
    logic                       tick;
    logic                       pre_tick_c;

    assign abort_c     = mc_abort_i && (state != ST_IDLE);
    assign div_term_c  = (clk_div_q == '0) ? PARAM_DIV_WIDTH'(1) : clk_div_q;
    assign last_edge_c = load_type_q[LT_WORD_BIT] ? LAST_WORD : LAST_HALF;
    assign div_en_c    = (state == ST_LEAD) || (state == ST_XFER) || (state == ST_TRAIL);
    assign in_frame_c  = (state_next == ST_LOAD) || (state_next == ST_LEAD) ||
                         (state_next == ST_XFER) || (state_next == ST_TRAIL);
    assign div_clr_c   = (state_next != state) &&
                         ((state_next == ST_LEAD) || (state_next == ST_XFER) || (state_next == ST_TRAIL));

    spi_ip_clk_div #(
        .DIV_WIDTH (PARAM_DIV_WIDTH)
    ) u_clk_div (
        .clk        (mc_clk_i),
        .rst_n      (mc_rst_n_i),
        .enable     (div_en_c),
        .clear      (div_clr_c),
        .terminal   (div_term_c),
        .tick       (tick),
        .pre_tick_c (pre_tick_c)
    );

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (mc_start_i) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_LEAD;
            ST_LEAD:  if (tick) state_next = ST_XFER;
            ST_XFER:  if (last_q) state_next = ST_TRAIL;
            ST_TRAIL: if (tick) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (abort_c) state_next = ST_IDLE;
    end

    // Strobe decode: launch is registered from the pre-tick so it lands in the tick
    // cycle; capture is registered from the tick so it follows the SCLK edge.
    always_comb begin
        launch_c  = 1'b0;
        capture_c = 1'b0;
        last_c    = 1'b0;
        if (state == ST_LEAD) begin
            launch_c = pre_tick_c && !cpha_q;
        end else if (state == ST_XFER) begin
            launch_c  = pre_tick_c &&
                        (edge_cnt[0] ? (!cpha_q && (edge_cnt != last_edge_c)) : cpha_q);
            capture_c = tick && (edge_cnt[0] ? cpha_q : !cpha_q);
            last_c    = tick && (edge_cnt == last_edge_c);
        end
        if (abort_c) begin
            launch_c  = 1'b0;
            capture_c = 1'b0;
            last_c    = 1'b0;
        end
    end

    always_ff @(posedge mc_clk_i or negedge mc_rst_n_i) begin
        if (!mc_rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs decoded from the upcoming state
    always_ff @(posedge mc_clk_i or negedge mc_rst_n_i) begin
        if (!mc_rst_n_i) begin
            ss_n_q    <= 1'b1;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            launch_q  <= 1'b0;
            capture_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            ss_n_q    <= !in_frame_c;
            load_q    <= state_next == ST_LOAD;
            busy_q    <= state_next != ST_IDLE;
            done_q    <= state_next == ST_DONE;
            launch_q  <= launch_c;
            capture_q <= capture_c;
            last_q    <= last_c;
        end
    end

    // Configuration latch, SCLK generation and edge counting
    always_ff @(posedge mc_clk_i or negedge mc_rst_n_i) begin
        if (!mc_rst_n_i) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            load_type_q <= '0;
            clk_div_q   <= '0;
            sclk_q      <= 1'b0;
            edge_cnt    <= '0;
        end else if (state == ST_IDLE && mc_start_i) begin
            cpol_q                   <= mc_cpol_i;
            cpha_q                   <= mc_cpha_i;
            load_type_q[LT_WORD_BIT] <= mc_load_type_i[LT_WORD_BIT];
            load_type_q[LT_LSB_BIT]  <= mc_load_type_i[LT_LSB_BIT];
            clk_div_q                <= mc_clk_div_i;
            sclk_q                   <= mc_cpol_i;
            edge_cnt                 <= '0;
        end else if (state_next == ST_IDLE) begin
            sclk_q <= cpol_q;
        end else if (state == ST_XFER && tick) begin
            sclk_q   <= !sclk_q;
            edge_cnt <= edge_cnt + EDGE_W'(1);
        end
    end

    assign mc_sclk_o                     = sclk_q;
    assign mc_ss_n_o                     = ss_n_q;
    assign mc_sr_load_o                  = load_q;
    assign mc_sr_enable_launch_o         = launch_q;
    assign mc_sr_enable_capture_o        = capture_q;
    assign mc_sr_enable_launch_capture_o = busy_q;
    assign mc_sr_load_type_o             = load_type_q;
    assign mc_busy_o                     = busy_q;
    assign mc_done_o                     = done_q;

endmodule

// File: doc/spi_ip_master_ctrl.md
SPI_IP_MASTER_CTRL -- requirements
Module: spi_ip_master_ctrl

Interface
REQ-001 SHALL have parameter PARAM_SR_WIDTH, default 16, shift-register width in bits (power of two, >=4).
REQ-002 SHALL have parameter PARAM_DIV_WIDTH, default 8, width of the SCLK divider value.
REQ-003 mc_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 mc_rst_n_i  in  1  asynchronous active-low reset.
REQ-005 mc_start_i  in  1  transfer request; sampled only in IDLE.
REQ-006 mc_abort_i  in  1  terminate the current transfer.
REQ-007 mc_cpol_i / mc_cpha_i  in  1 each  SPI clock polarity and phase.
REQ-008 mc_load_type_i  in  2  bit0 = 1 word / 0 half-word; bit1 = 1 LSB-first / 0 MSB-first; forwarded to the shift register.
REQ-009 mc_clk_div_i  in  PARAM_DIV_WIDTH  SCLK half-period minus one, in mc_clk_i cycles.
REQ-010 mc_sclk_o, mc_ss_n_o  out  1 each  SPI clock and active-low slave select.
REQ-011 mc_sr_load_o, mc_sr_enable_launch_o, mc_sr_enable_capture_o, mc_sr_enable_launch_capture_o  out  1 each  shift-register controls.
REQ-012 mc_sr_load_type_o  out  2  latched copy of mc_load_type_i.
REQ-013 mc_busy_o, mc_done_o  out  1 each  transfer in progress; one-cycle completion pulse.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, LEAD, XFER, TRAIL, DONE.
REQ-015 IDLE: ss_n=1, sclk=latched cpol, busy=0; mc_start_i=1 latches cpol, cpha, load_type, clk_div and goes to LOAD.
REQ-016 LOAD: mc_sr_load_o=1 for exactly one cycle, ss_n drops to 0; next state LEAD.
REQ-017 Divider SHALL count 0..D, D = max(clk_div,1), asserting an internal tick when count==D and restarting at 0; it runs only in LEAD, XFER, TRAIL and clears on entering each.
REQ-018 LEAD: lasts until first tick; if cpha=0 mc_sr_enable_launch_o pulses on that tick (first bit presented before first edge); next XFER.
REQ-019 XFER: each tick toggles sclk and increments edge counter e (0..2N-1, N=PARAM_SR_WIDTH if word else PARAM_SR_WIDTH/2).
REQ-020 Even e = leading edge, odd e = trailing edge; cpha=0: capture on leading, launch on trailing except e=2N-1; cpha=1: launch on leading, capture on trailing.
REQ-021 Launch enable SHALL pulse in the tick cycle; capture enable SHALL pulse one cycle after the tick, so sampling follows the registered sclk edge.
REQ-022 After the tick of e=2N-1 (sclk back at cpol) and its capture pulse, go to TRAIL; TRAIL lasts one tick with ss_n=0, then DONE.
REQ-023 DONE: ss_n=1, mc_done_o=1 for one cycle, then IDLE.
REQ-024 mc_sr_enable_launch_capture_o and mc_busy_o SHALL be 1 in LOAD..DONE exclusive of IDLE, else 0.
REQ-025 mc_start_i while busy SHALL be ignored; config changes while busy have no effect.
REQ-026 mc_abort_i=1 in any non-IDLE state SHALL force IDLE next cycle: ss_n=1, sclk=cpol, no done pulse, no further enables; abort has priority over start and ticks.
REQ-027 Exactly N capture and N launch pulses per completed transfer.

Reset
REQ-028 Reset SHALL force IDLE, ss_n=1, sclk=0, all enables, load, busy, done =0, counters and latched config =0, independent of the clock.
REQ-029 Reset mid-transfer SHALL abandon it with no done pulse.

Structure
REQ-030 State encoding and load_type bit-index constants SHALL live in package spi_ip_pkg.
REQ-031 The divider SHALL be sub-module spi_ip_clk_div (enable, clear, terminal value, tick out).

Verification
REQ-032 Word, cpol=0, cpha=0, clk_div=1: 32 sclk edges, 16 captures, 16 launches, ss_n low 70+ cycles, done one pulse.
REQ-033 Half-word, cpha=1, cpol=1: sclk idles 1, 8 captures all on rising edges, done after TRAIL.
REQ-034 clk_div=0 behaves identically to clk_div=1 (half-period 2 cycles).
REQ-035 Abort after 5th capture: next cycle ss_n=1, busy=0, no done; new start accepted next cycle.
REQ-036 start held high continuously: back-to-back transfers, one IDLE cycle between done and next load.
REQ-037 Async reset asserted mid-XFER between clock edges: outputs reach reset values without a clock edge.
